// File: rtl/alu_v2_sequencer.sv
// alu_v2_sequencer
// ----------------------------------------------------------------------------
// Control sequencer for the ALU_v2 datapath. It accepts one command at a time,
// walks the ALU register enables through a fixed issue order and waits out the
// multiply-stage latency. It then captures alu_result and returns it as a
// response.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds valid and its payload stable
// until that transfer. Ready may depend on state but never on the valid it
// qualifies. cmd_* is the command channel into this block. rsp_* is the
// response channel out of it.
//
// Parameters
//   BUS_WIDTH  datapath width, must match ALU_v2 (default 8)
//   MULT_LAT   cycles spent in WAIT before the result is sampled, 1..15
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command channel; ready only in IDLE
//   cmd_op_i                00 NOP, 01 LOAD_SW, 10 ADD_IMM, 11 MAC
//   cmd_imm_i               immediate for ADD_IMM
//   alu_reg_en_o            [0] a, [1] b, [2] c, [3] d, [4] op_e register
//   alu_add_o, alu_load_o   ALU_v2 mode controls
//   alu_imm_o               ALU_v2 immediate
//   alu_result_i            ALU_v2 result
//   rsp_valid_o/ready_i     response channel
//   rsp_data_o              captured result
//   busy_o                  high in any state other than IDLE
//   op_count_o              completed-response counter; exists only when
//                           ALU_SEQ_PERF_CNT_EN is defined
//
// Configuration macro: ALU_SEQ_PERF_CNT_EN adds the 16-bit op_count_o counter.
// ----------------------------------------------------------------------------
module alu_v2_sequencer #(
  parameter int BUS_WIDTH = 8,
  parameter int MULT_LAT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [BUS_WIDTH-1:0] cmd_imm_i,
  output logic [4:0]           alu_reg_en_o,
  output logic                 alu_add_o,
  output logic                 alu_load_o,
  output logic [BUS_WIDTH-1:0] alu_imm_o,
  input  logic [BUS_WIDTH-1:0] alu_result_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [BUS_WIDTH-1:0] rsp_data_o,
  output logic                 busy_o
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]          op_count_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISS_AB = 3'd1,
    S_ISS_CD = 3'd2,
    S_ISS_E  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_ADD_IMM = 2'b10;
  localparam logic [1:0] OP_MAC     = 2'b11;

  // WAIT counts down from MULT_LAT-1 to 0; the result is sampled at 0.
  localparam logic [3:0] WAIT_LOAD = 4'(MULT_LAT - 1);

  state_t                 state_q, state_d;
  logic [4:0]             reg_en_q, reg_en_d;
  logic                   add_q, add_d;
  logic                   load_q, load_d;
  logic [BUS_WIDTH-1:0]   imm_q, imm_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   accept;

  // Ready is gated by rst_i so that nothing is offered during the reset cycle.
  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    reg_en_d    = reg_en_q;
    add_d       = add_q;
    load_d      = load_q;
    imm_d       = imm_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        // A NOP is consumed here and never leaves IDLE.
        if (accept && (cmd_op_i != OP_NOP)) begin
          state_d  = S_ISS_AB;
          reg_en_d = 5'b00011;
          add_d    = (cmd_op_i == OP_ADD_IMM);
          load_d   = (cmd_op_i == OP_MAC);
          imm_d    = (cmd_op_i == OP_ADD_IMM) ? cmd_imm_i : '0;
        end
      end
      S_ISS_AB: begin
        state_d  = S_ISS_CD;
        reg_en_d = 5'b01100;
      end
      S_ISS_CD: begin
        state_d  = S_ISS_E;
        reg_en_d = 5'b10000;
      end
      S_ISS_E: begin
        state_d  = S_WAIT;
        reg_en_d = 5'b00000;
        cnt_d    = WAIT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result_i;
          add_d       = 1'b0;
          load_d      = 1'b0;
          imm_d       = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      reg_en_q    <= '0;
      add_q       <= 1'b0;
      load_q      <= 1'b0;
      imm_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      reg_en_q    <= reg_en_d;
      add_q       <= add_d;
      load_q      <= load_d;
      imm_q       <= imm_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign alu_reg_en_o = reg_en_q;
  assign alu_add_o    = add_q;
  assign alu_load_o   = load_q;
  assign alu_imm_o    = imm_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = (state_q != S_IDLE);

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] op_count_q;

  // Counts completed response handshakes and wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_alu_v2_sequencer.sv
module tb_alu_v2_sequencer;
  localparam int W   = 8;
  localparam int ML  = 1;
  localparam int ML3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (MULT_LAT=1) ----------------
  logic         cmd_valid, cmd_ready, alu_add, alu_load, rsp_valid, rsp_ready, busy;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_imm, alu_imm, alu_result, rsp_data;
  logic [4:0]   reg_en;

  // ---------------- DUT (MULT_LAT=3) ----------------
  logic         cmd_valid3, cmd_ready3, alu_add3, alu_load3, rsp_valid3, rsp_ready3, busy3;
  logic [1:0]   cmd_op3;
  logic [W-1:0] cmd_imm3, alu_imm3, alu_result3, rsp_data3;
  logic [4:0]   reg_en3;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] op_count, op_count3;
`endif

  alu_v2_sequencer #(.BUS_WIDTH(W), .MULT_LAT(ML)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_imm_i(cmd_imm),
    .alu_reg_en_o(reg_en), .alu_add_o(alu_add), .alu_load_o(alu_load),
    .alu_imm_o(alu_imm), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .op_count_o(op_count)
`endif
  );

  alu_v2_sequencer #(.BUS_WIDTH(W), .MULT_LAT(ML3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3),
    .cmd_op_i(cmd_op3), .cmd_imm_i(cmd_imm3),
    .alu_reg_en_o(reg_en3), .alu_add_o(alu_add3), .alu_load_o(alu_load3),
    .alu_imm_o(alu_imm3), .alu_result_i(alu_result3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_data_o(rsp_data3),
    .busy_o(busy3)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .op_count_o(op_count3)
`endif
  );

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  n_hs = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-op ALU controls as {add, load, imm}.
  function automatic logic [W+1:0] model_ctrl(input logic [1:0] op, input logic [W-1:0] imm);
    case (op)
      2'd2:    return {1'b1, 1'b0, imm};
      2'd3:    return {1'b0, 1'b1, {W{1'b0}}};
      default: return '0;
    endcase
  endfunction

  // Register-enable pattern k cycles after acceptance.
  function automatic logic [4:0] model_reg_en(input int k);
    if (k == 1) return 5'b00011;
    if (k == 2) return 5'b01100;
    if (k == 3) return 5'b10000;
    return 5'b00000;
  endfunction

  // ---------------- driver: one command on the MULT_LAT=1 DUT ----------------
  // Entered and left just after a rising edge with the DUT expected in IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] imm, input logic [W-1:0] res,
                         input int bp, input logic e_add, input logic e_load, input logic [W-1:0] e_imm,
                         input bit hold_next, input logic [1:0] n_op, input logic [W-1:0] n_imm);
    int  k;
    bit  done;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_imm    = imm;
    alu_result = W'($urandom);
    rsp_ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_reg_en", 32'(reg_en), 32'd0);
    chk("idle_ctrl", 32'({alu_add, alu_load, alu_imm}), 32'd0);
    @(posedge clk); #1;
    if (op != 2'd0) exp_q.push_back(res);
    if (hold_next) begin
      cmd_op  = n_op;
      cmd_imm = n_imm;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_imm   = W'($urandom);
    end
    if (op == 2'd0) return;
    done = 1'b0;
    k    = 1;
    while (!done && k < 64) begin
      alu_result = (k == 3 + ML) ? res : W'($urandom);
      if (k >= 4 + ML) rsp_ready = (k - (4 + ML)) >= bp;
      else             rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reg_en", 32'(reg_en), 32'(model_reg_en(k)));
      if (k <= 3 + ML) chk("ctrl_active", 32'({alu_add, alu_load, alu_imm}), 32'({e_add, e_load, e_imm}));
      else             chk("ctrl_resp", 32'({alu_add, alu_load, alu_imm}), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(k >= 4 + ML));
      chk("busy", 32'(busy), 32'd1);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (k >= 4 + ML) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        if (rsp_ready) done = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("rsp_handshake_seen", 32'(done), 32'd1);
    void'(exp_q.pop_front());
    n_hs++;
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] imm;
    logic [W-1:0] res;
    int           bp;
    logic         e_add;
    logic         e_load;
    logic [W-1:0] e_imm;
    bit           hold;
    logic [1:0]   n_op;
    logic [W-1:0] n_imm;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]   pend_op, op;
    logic [W-1:0] pend_imm, imm;
    logic [W+1:0] ctrl;
    bit           hold;

    tbl[0] = '{2'd3, 8'h33, 8'h5A, 0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00};
    tbl[1] = '{2'd2, 8'h7F, 8'h81, 0, 1'b1, 1'b0, 8'h7F, 1'b0, 2'd0, 8'h00};
    tbl[2] = '{2'd1, 8'hAA, 8'h3C, 4, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h11};
    tbl[3] = '{2'd2, 8'h11, 8'hC3, 1, 1'b1, 1'b0, 8'h11, 1'b0, 2'd0, 8'h00};
    tbl[4] = '{2'd0, 8'hFF, 8'h99, 0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 8'h00};
    tbl[5] = '{2'd1, 8'h00, 8'h00, 2, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00};
    tbl[6] = '{2'd3, 8'h01, 8'hFF, 0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00};
    tbl[7] = '{2'd2, 8'h00, 8'h7E, 0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; alu_result = '0; rsp_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_op3 = '0; cmd_imm3 = '0; alu_result3 = '0; rsp_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_outputs", 32'({reg_en, alu_add, alu_load, alu_imm, rsp_valid, busy}), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].op, tbl[i].imm, tbl[i].res, tbl[i].bp, tbl[i].e_add, tbl[i].e_load,
              tbl[i].e_imm, tbl[i].hold, tbl[i].n_op, tbl[i].n_imm);
    end

    // Randomized commands against the model
    pend_op  = 2'($urandom_range(0, 3));
    pend_imm = W'($urandom);
    for (int i = 0; i < 40; i++) begin
      op       = pend_op;
      imm      = pend_imm;
      pend_op  = 2'($urandom_range(0, 3));
      pend_imm = W'($urandom);
      hold     = (i != 39) && ($urandom_range(0, 1) == 1);
      ctrl     = model_ctrl(op, imm);
      run_cmd(op, imm, W'($urandom), $urandom_range(0, 3), ctrl[W+1], ctrl[W], ctrl[W-1:0],
              hold, pend_op, pend_imm);
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    @(negedge clk);
    chk("op_count", 32'(op_count), 32'(n_hs));
    @(posedge clk); #1;
`endif

    // Reset held 3 cycles while a MAC sits in WAIT
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_imm = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_load", 32'(alu_load), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_outputs", 32'({reg_en, alu_add, alu_load, alu_imm, rsp_valid, busy, cmd_ready}), 32'd0);
      chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_hs = 16'd0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("post_rst_op_count", 32'(op_count), 32'd0);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("discarded_no_rsp", 32'({rsp_valid, busy}), 32'd0);
    end
    @(posedge clk); #1;

    // MULT_LAT=3 instance: two MACs
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] res3;
      bit           seen;
      res3 = (i == 0) ? 8'hA5 : 8'h3C;
      seen = 1'b0;
      cmd_valid3 = 1'b1; cmd_op3 = 2'd3; cmd_imm3 = W'($urandom);
      @(negedge clk);
      chk("ml3_cmd_ready", 32'(cmd_ready3), 32'd1);
      @(posedge clk); #1;
      cmd_valid3 = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        alu_result3 = (k == 6) ? res3 : W'($urandom);
        rsp_ready3  = (k >= 7);
        @(negedge clk);
        chk("ml3_reg_en", 32'(reg_en3), 32'(model_reg_en(k)));
        chk("ml3_load", 32'(alu_load3), 32'(k <= 6));
        chk("ml3_rsp_valid", 32'(rsp_valid3), 32'(k == 7));
        if (k == 7) begin
          chk("ml3_rsp_data", 32'(rsp_data3), 32'(res3));
          seen = 1'b1;
        end
        @(posedge clk); #1;
      end
      chk("ml3_handshake_seen", 32'(seen), 32'd1);
      rsp_ready3 = 1'b0;
    end
    @(negedge clk);
    chk("ml3_idle", 32'({cmd_ready3, busy3, rsp_valid3}), 32'b100);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("ml3_op_count", 32'(op_count3), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
